// File: rtl/decode_stage.sv
// decode_stage: RV32I/RV64I instruction decoder followed by a small output FIFO.
//
// The incoming instruction is decoded combinationally and the decoded record is
// written into a DEPTH-entry buffer on accept; the head entry drives out_*.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid/in_ready        fetch-side handshake
//   in_inst, in_pc           instruction word and its address
//   flush                    drop every buffered entry; blocks enqueue this cycle
//   out_valid/out_ready      consumer handshake on the head entry
//   out_pc                   head entry pc
//   out_rd/out_rs1/out_rs2   raw register fields of the instruction
//   out_imm                  sign-extended immediate (zero-extended shamt for shifts)
//   out_alu_op               one-hot ALU operation
//   out_ctrl                 {need_imm, reg_wen, mem_wen, is_load, is_branch,
//                             is_jal, is_jalr, is_ebreak}
//   out_wmask                store byte mask
//   out_lsize, out_lunsigned access size and zero-extend flag
//   out_word                 *W instruction (RV64 only)
//   out_illegal              instruction not decodable
//   count                    buffer occupancy
module decode_stage #(
    parameter int XLEN    = 64,
    parameter int DEPTH   = 2,
    parameter int ALUOP_W = 15
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_inst,
    input  logic [XLEN-1:0]            in_pc,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XLEN-1:0]            out_pc,
    output logic [4:0]                 out_rd,
    output logic [4:0]                 out_rs1,
    output logic [4:0]                 out_rs2,
    output logic [XLEN-1:0]            out_imm,
    output logic [ALUOP_W-1:0]         out_alu_op,
    output logic [7:0]                 out_ctrl,
    output logic [XLEN/8-1:0]          out_wmask,
    output logic [1:0]                 out_lsize,
    output logic                       out_lunsigned,
    output logic                       out_word,
    output logic                       out_illegal,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int MW = XLEN / 8;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam bit IS64 = (XLEN == 64);

    // one-hot ALU operation bit positions; branches use the compare ops
    localparam int A_ADD = 0,  A_SUB = 1,  A_SLL = 2,  A_SLT = 3,  A_SLTU = 4;
    localparam int A_XOR = 5,  A_SRL = 6,  A_SRA = 7,  A_OR  = 8,  A_AND  = 9;
    localparam int A_LUI = 10, A_EQ  = 11, A_NE  = 12, A_GE  = 13, A_GEU  = 14;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [4:0]         rd;
        logic [4:0]         rs1;
        logic [4:0]         rs2;
        logic [XLEN-1:0]    imm;
        logic [ALUOP_W-1:0] alu_op;
        logic [7:0]         ctrl;
        logic [MW-1:0]      wmask;
        logic [1:0]         lsize;
        logic               lunsigned;
        logic               word;
        logic               illegal;
    } rec_t;

    // R-type style funct3 -> ALU op; alt selects SUB/SRA
    function automatic logic [ALUOP_W-1:0] alu_of(input logic [2:0] f3, input logic alt);
        logic [ALUOP_W-1:0] op;
        op = '0;
        case (f3)
            3'b000:  op[alt ? A_SUB : A_ADD] = 1'b1;
            3'b001:  op[A_SLL]  = 1'b1;
            3'b010:  op[A_SLT]  = 1'b1;
            3'b011:  op[A_SLTU] = 1'b1;
            3'b100:  op[A_XOR]  = 1'b1;
            3'b101:  op[alt ? A_SRA : A_SRL] = 1'b1;
            3'b110:  op[A_OR]   = 1'b1;
            default: op[A_AND]  = 1'b1;
        endcase
        return op;
    endfunction

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    rec_t        dec;
    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    logic        ok, need_imm, reg_wen, mem_wen, is_load, is_branch, is_jal, is_jalr, is_ebreak;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opc = in_inst[6:0];
    assign f3  = in_inst[14:12];
    assign f7  = in_inst[31:25];

    assign imm_i = {{20{in_inst[31]}}, in_inst[31:20]};
    assign imm_s = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
    assign imm_b = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
    assign imm_u = {in_inst[31:12], 12'b0};
    assign imm_j = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};

    always_comb begin
        dec       = '0;
        dec.pc    = in_pc;
        dec.rd    = in_inst[11:7];
        dec.rs1   = in_inst[19:15];
        dec.rs2   = in_inst[24:20];
        ok        = 1'b0;
        need_imm  = 1'b0;
        reg_wen   = 1'b0;
        mem_wen   = 1'b0;
        is_load   = 1'b0;
        is_branch = 1'b0;
        is_jal    = 1'b0;
        is_jalr   = 1'b0;
        is_ebreak = 1'b0;

        case (opc)
            7'b0110111: begin // LUI
                ok = 1'b1; need_imm = 1'b1; reg_wen = 1'b1;
                dec.imm = XLEN'($signed(imm_u));
                dec.alu_op[A_LUI] = 1'b1;
            end
            7'b0010111: begin // AUIPC
                ok = 1'b1; need_imm = 1'b1; reg_wen = 1'b1;
                dec.imm = XLEN'($signed(imm_u));
                dec.alu_op[A_ADD] = 1'b1;
            end
            7'b1101111: begin // JAL
                ok = 1'b1; need_imm = 1'b1; reg_wen = 1'b1; is_jal = 1'b1;
                dec.imm = XLEN'($signed(imm_j));
                dec.alu_op[A_ADD] = 1'b1;
            end
            7'b1100111: begin // JALR
                ok = (f3 == 3'b000); need_imm = 1'b1; reg_wen = 1'b1; is_jalr = 1'b1;
                dec.imm = XLEN'($signed(imm_i));
                dec.alu_op[A_ADD] = 1'b1;
            end
            7'b1100011: begin // BRANCH
                ok = (f3 != 3'b010) && (f3 != 3'b011);
                is_branch = 1'b1;
                dec.imm = XLEN'($signed(imm_b));
                case (f3)
                    3'b000:  dec.alu_op[A_EQ]   = 1'b1;
                    3'b001:  dec.alu_op[A_NE]   = 1'b1;
                    3'b100:  dec.alu_op[A_SLT]  = 1'b1;
                    3'b101:  dec.alu_op[A_GE]   = 1'b1;
                    3'b110:  dec.alu_op[A_SLTU] = 1'b1;
                    default: dec.alu_op[A_GEU]  = 1'b1;
                endcase
            end
            7'b0000011: begin // LOAD
                ok = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                     (f3 == 3'b100) || (f3 == 3'b101) ||
                     (IS64 && ((f3 == 3'b011) || (f3 == 3'b110)));
                need_imm = 1'b1; reg_wen = 1'b1; is_load = 1'b1;
                dec.imm = XLEN'($signed(imm_i));
                dec.alu_op[A_ADD] = 1'b1;
                dec.lsize     = f3[1:0];
                dec.lunsigned = f3[2];
            end
            7'b0100011: begin // STORE
                ok = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                     (IS64 && (f3 == 3'b011));
                need_imm = 1'b1; mem_wen = 1'b1;
                dec.imm = XLEN'($signed(imm_s));
                dec.alu_op[A_ADD] = 1'b1;
                dec.lsize = f3[1:0];
                for (int i = 0; i < MW; i++)
                    dec.wmask[i] = (i < (1 << f3[1:0]));
            end
            7'b0010011: begin // OP-IMM
                need_imm = 1'b1; reg_wen = 1'b1;
                dec.imm = XLEN'($signed(imm_i));
                if (f3 == 3'b001 || f3 == 3'b101) begin
                    // shifts: legal funct6/funct7 depends on shamt width
                    if (IS64) begin
                        ok = (in_inst[31:26] == 6'b000000) ||
                             (f3 == 3'b101 && in_inst[31:26] == 6'b010000);
                        dec.imm = XLEN'(in_inst[25:20]);
                    end else begin
                        ok = (f7 == 7'b0000000) || (f3 == 3'b101 && f7 == 7'b0100000);
                        dec.imm = XLEN'(in_inst[24:20]);
                    end
                    dec.alu_op = alu_of(f3, in_inst[30]);
                end else begin
                    ok = 1'b1;
                    dec.alu_op = alu_of(f3, 1'b0);
                end
            end
            7'b0110011: begin // OP
                reg_wen = 1'b1;
                ok = (f7 == 7'b0000000) ||
                     (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101));
                dec.alu_op = alu_of(f3, in_inst[30]);
            end
            7'b0011011: begin // OP-IMM-32
                need_imm = 1'b1; reg_wen = 1'b1; dec.word = 1'b1;
                if (f3 == 3'b000) begin
                    ok = IS64;
                    dec.imm = XLEN'($signed(imm_i));
                    dec.alu_op = alu_of(f3, 1'b0);
                end else begin
                    ok = IS64 && ((f3 == 3'b001 && f7 == 7'b0000000) ||
                                  (f3 == 3'b101 && (f7 == 7'b0000000 || f7 == 7'b0100000)));
                    dec.imm = XLEN'(in_inst[24:20]);
                    dec.alu_op = alu_of(f3, in_inst[30]);
                end
            end
            7'b0111011: begin // OP-32
                reg_wen = 1'b1; dec.word = 1'b1;
                ok = IS64 && ((f7 == 7'b0000000 && (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b101)) ||
                              (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)));
                dec.alu_op = alu_of(f3, in_inst[30]);
            end
            7'b1110011: begin // SYSTEM: only ebreak
                ok = (in_inst == 32'h0010_0073);
                is_ebreak = 1'b1;
            end
            default: ok = 1'b0;
        endcase

        dec.ctrl = {need_imm, reg_wen, mem_wen, is_load, is_branch, is_jal, is_jalr, is_ebreak};

        // an undecodable word travels down the pipe with every side-effect bit cleared
        if (!ok) begin
            dec.imm       = '0;
            dec.alu_op    = '0;
            dec.ctrl      = '0;
            dec.wmask     = '0;
            dec.lsize     = '0;
            dec.lunsigned = 1'b0;
            dec.word      = 1'b0;
            dec.illegal   = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------------
    rec_t          mem [DEPTH];
    rec_t          head;
    logic [PW-1:0] rptr, wptr;
    logic [CW-1:0] cnt;
    logic          enq, deq;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign out_valid = (cnt != '0);
    assign deq       = out_valid & out_ready;
    // rst and flush gate in_ready so nothing is accepted while state is being cleared
    assign in_ready  = ~rst & ~flush & ((cnt < CW'(DEPTH)) | deq);
    assign enq       = in_valid & in_ready;
    assign count     = cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            rptr <= '0;
            wptr <= '0;
        end else if (flush) begin
            cnt  <= '0;
            rptr <= '0;
            wptr <= '0;
        end else begin
            if (enq) wptr <= ptr_inc(wptr);
            if (deq) rptr <= ptr_inc(rptr);
            case ({enq, deq})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // payload needs no reset: it is only observed while out_valid=1
    always_ff @(posedge clk) begin
        if (enq) mem[wptr] <= dec;
    end

    assign head          = mem[rptr];
    assign out_pc        = head.pc;
    assign out_rd        = head.rd;
    assign out_rs1       = head.rs1;
    assign out_rs2       = head.rs2;
    assign out_imm       = head.imm;
    assign out_alu_op    = head.alu_op;
    assign out_ctrl      = head.ctrl;
    assign out_wmask     = head.wmask;
    assign out_lsize     = head.lsize;
    assign out_lunsigned = head.lunsigned;
    assign out_word      = head.word;
    assign out_illegal   = head.illegal;

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, flush, out_ready;
    logic [31:0] in_inst;
    logic [63:0] in_pc;
    logic [31:0] in_pc32;

    logic        in_ready, out_valid;
    logic [63:0] out_pc, out_imm;
    logic [4:0]  out_rd, out_rs1, out_rs2;
    logic [14:0] out_alu_op;
    logic [7:0]  out_ctrl, out_wmask;
    logic [1:0]  out_lsize, count;
    logic        out_lunsigned, out_word, out_illegal;

    logic        in_ready32, out_valid32;
    logic [31:0] out_pc32, out_imm32;
    logic [4:0]  out_rd32, out_rs1_32, out_rs2_32;
    logic [14:0] out_alu_op32;
    logic [7:0]  out_ctrl32;
    logic [3:0]  out_wmask32;
    logic [1:0]  out_lsize32, count32;
    logic        out_lunsigned32, out_word32, out_illegal32;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    decode_stage #(.XLEN(64), .DEPTH(2), .ALUOP_W(15)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_imm(out_imm),
        .out_alu_op(out_alu_op), .out_ctrl(out_ctrl), .out_wmask(out_wmask),
        .out_lsize(out_lsize), .out_lunsigned(out_lunsigned), .out_word(out_word),
        .out_illegal(out_illegal), .count(count)
    );

    decode_stage #(.XLEN(32), .DEPTH(2), .ALUOP_W(15)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready32),
        .in_inst(in_inst), .in_pc(in_pc32), .flush(flush),
        .out_valid(out_valid32), .out_ready(out_ready), .out_pc(out_pc32),
        .out_rd(out_rd32), .out_rs1(out_rs1_32), .out_rs2(out_rs2_32), .out_imm(out_imm32),
        .out_alu_op(out_alu_op32), .out_ctrl(out_ctrl32), .out_wmask(out_wmask32),
        .out_lsize(out_lsize32), .out_lunsigned(out_lunsigned32), .out_word(out_word32),
        .out_illegal(out_illegal32), .count(count32)
    );

    typedef struct {
        logic [31:0] inst;
        logic [4:0]  rd, rs1, rs2;
        logic [63:0] imm;
        logic [14:0] alu;
        logic [7:0]  ctrl, wmask;
        logic [1:0]  lsize;
        logic        lu, word, ill, ill32;
    } vec_t;

    vec_t vecs [15];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        //             inst          rd  rs1 rs2 imm                    alu       ctrl   wmask  ls  lu  w  ill ill32
        vecs[0]  = '{32'h00500093, 1,  0,  5,  64'd5,                 15'h0001, 8'hC0, 8'h00, 0, 0, 0, 0, 0}; // addi x1,x0,5
        vecs[1]  = '{32'h0020B423, 8,  1,  2,  64'd8,                 15'h0001, 8'hA0, 8'hFF, 3, 0, 0, 0, 1}; // sd x2,8(x1)
        vecs[2]  = '{32'hFFC12183, 3,  2,  28, 64'hFFFF_FFFF_FFFF_FFFC, 15'h0001, 8'hD0, 8'h00, 2, 0, 0, 0, 0}; // lw x3,-4(x2)
        vecs[3]  = '{32'h00100073, 0,  0,  1,  64'd0,                 15'h0000, 8'h01, 8'h00, 0, 0, 0, 0, 0}; // ebreak
        vecs[4]  = '{32'h00000000, 0,  0,  0,  64'd0,                 15'h0000, 8'h00, 8'h00, 0, 0, 0, 1, 1}; // all-zero word
        vecs[5]  = '{32'h007302B3, 5,  6,  7,  64'd0,                 15'h0001, 8'h40, 8'h00, 0, 0, 0, 0, 0}; // add
        vecs[6]  = '{32'h407302B3, 5,  6,  7,  64'd0,                 15'h0002, 8'h40, 8'h00, 0, 0, 0, 0, 0}; // sub
        vecs[7]  = '{32'h43F15093, 1,  2,  31, 64'd63,                15'h0080, 8'hC0, 8'h00, 0, 0, 0, 0, 1}; // srai x1,x2,63
        vecs[8]  = '{32'h00209863, 16, 1,  2,  64'd16,                15'h1000, 8'h08, 8'h00, 0, 0, 0, 0, 0}; // bne +16
        vecs[9]  = '{32'h12345537, 10, 8,  3,  64'h0000_0000_1234_5000, 15'h0400, 8'hC0, 8'h00, 0, 0, 0, 0, 0}; // lui
        vecs[10] = '{32'hFFDFF0EF, 1,  31, 29, 64'hFFFF_FFFF_FFFF_FFFC, 15'h0001, 8'hC4, 8'h00, 0, 0, 0, 0, 0}; // jal -4
        vecs[11] = '{32'h0012C203, 4,  5,  1,  64'd1,                 15'h0001, 8'hD0, 8'h00, 0, 1, 0, 0, 0}; // lbu
        vecs[12] = '{32'hFFF0809B, 1,  1,  31, 64'hFFFF_FFFF_FFFF_FFFF, 15'h0001, 8'hC0, 8'h00, 0, 0, 1, 0, 1}; // addiw
        vecs[13] = '{32'h00321123, 2,  4,  3,  64'd2,                 15'h0001, 8'hA0, 8'h03, 1, 0, 0, 0, 0}; // sh
        vecs[14] = '{32'h0020A063, 0,  1,  2,  64'd0,                 15'h0000, 8'h00, 8'h00, 0, 0, 0, 1, 1}; // branch f3=010

        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        in_inst = 32'h0; in_pc = 64'h0; in_pc32 = 32'h0;

        // reset state, before any clock edge
        #2;
        chk("rst.out_valid", 64'(out_valid), 64'd0);
        chk("rst.in_ready",  64'(in_ready),  64'd0);
        chk("rst.count",     64'(count),     64'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst.in_ready",  64'(in_ready),  64'd1);
        chk("post_rst.out_valid", 64'(out_valid), 64'd0);

        // decode vectors, one per cycle, consumer always ready
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_inst = vecs[i].inst;
            in_pc = 64'h1000 + 64'(i * 4); in_pc32 = 32'h1000 + 32'(i * 4);
            @(posedge clk); #1;
            chk($sformatf("v%0d.valid", i), 64'(out_valid),     64'd1);
            chk($sformatf("v%0d.pc", i),    out_pc,              64'h1000 + 64'(i * 4));
            chk($sformatf("v%0d.rd", i),    64'(out_rd),         64'(vecs[i].rd));
            chk($sformatf("v%0d.rs1", i),   64'(out_rs1),        64'(vecs[i].rs1));
            chk($sformatf("v%0d.rs2", i),   64'(out_rs2),        64'(vecs[i].rs2));
            chk($sformatf("v%0d.imm", i),   out_imm,             vecs[i].imm);
            chk($sformatf("v%0d.alu", i),   64'(out_alu_op),     64'(vecs[i].alu));
            chk($sformatf("v%0d.ctrl", i),  64'(out_ctrl),       64'(vecs[i].ctrl));
            chk($sformatf("v%0d.wmask", i), 64'(out_wmask),      64'(vecs[i].wmask));
            chk($sformatf("v%0d.lsize", i), 64'(out_lsize),      64'(vecs[i].lsize));
            chk($sformatf("v%0d.lu", i),    64'(out_lunsigned),  64'(vecs[i].lu));
            chk($sformatf("v%0d.word", i),  64'(out_word),       64'(vecs[i].word));
            chk($sformatf("v%0d.ill", i),   64'(out_illegal),    64'(vecs[i].ill));
            chk($sformatf("v%0d.ill32", i), 64'(out_illegal32),  64'(vecs[i].ill32));
            chk($sformatf("v%0d.word32", i), 64'(out_word32),    64'd0);
        end
        @(negedge clk); in_valid = 1'b0;
        @(posedge clk); #1;
        chk("drain.count", 64'(count), 64'd0);

        // backpressure: 3 offers into a 2-deep buffer, then simultaneous enq/deq
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; in_inst = 32'h00500093; in_pc = 64'h100;
        @(posedge clk); #1;
        @(negedge clk); in_pc = 64'h104;
        @(posedge clk); #1;
        chk("bp.count2", 64'(count), 64'd2);
        @(negedge clk); in_pc = 64'h108; #1;
        chk("bp.in_ready_full", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        chk("bp.count_hold", 64'(count), 64'd2);
        chk("bp.head_stable", out_pc, 64'h100);
        chk("bp.imm_stable",  out_imm, 64'd5);
        @(negedge clk); out_ready = 1'b1; #1;
        chk("bp.in_ready_deq", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        chk("bp.count_same", 64'(count), 64'd2);
        chk("bp.head_b", out_pc, 64'h104);
        @(negedge clk); in_valid = 1'b0;
        @(posedge clk); #1;
        chk("bp.head_c", out_pc, 64'h108);
        chk("bp.count1", 64'(count), 64'd1);
        @(posedge clk); #1;
        chk("bp.empty", 64'(out_valid), 64'd0);

        // flush with a same-cycle offer
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; in_pc = 64'h200;
        @(posedge clk); #1;
        @(negedge clk); in_pc = 64'h204;
        @(posedge clk); #1;
        chk("fl.count2", 64'(count), 64'd2);
        @(negedge clk); flush = 1'b1; in_pc = 64'h208; #1;
        chk("fl.in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        chk("fl.count0", 64'(count), 64'd0);
        chk("fl.valid0", 64'(out_valid), 64'd0);
        @(negedge clk); flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        chk("fl.no_ghost", 64'(out_valid), 64'd0);

        // asynchronous reset mid-operation
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; in_inst = 32'h00500093; in_pc = 64'h300;
        @(posedge clk); #1;
        @(negedge clk); in_valid = 1'b0;
        chk("ar.count1", 64'(count), 64'd1);
        @(posedge clk); #2;
        rst = 1'b1; #1;
        chk("ar.valid_drop", 64'(out_valid), 64'd0);
        chk("ar.count0",     64'(count),     64'd0);
        chk("ar.in_ready",   64'(in_ready),  64'd0);
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b1; in_inst = 32'h007302B3; in_pc = 64'h400;
        @(posedge clk); #1;
        chk("ar.first_valid", 64'(out_valid), 64'd1);
        chk("ar.first_pc",    out_pc,         64'h400);
        chk("ar.first_alu",   64'(out_alu_op), 64'h0001);
        @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        chk("ar.drained", 64'(count), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
